i2c_wb_sequencer: RTL

//  WISHBONE master placed directly upstream of the i2c master core (registers PRER/CTR/TXR/RXR/CR/SR).

---
 rtl/i2c_wb_sequencer_pkg.sv | 76 +++++++
 rtl/i2c_wb_access.sv | 46 ++++
 rtl/i2c_wb_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_wb_sequencer_pkg.sv
// Shared constants, types and the step table for the i2c WISHBONE sequencer.
package i2c_seq_pkg;

  // i2c master core register map (TXR/RXR and CR/SR share addresses)
  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_RXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;

  // CR bits
  localparam logic [7:0] CR_STA  = 8'h80;
  localparam logic [7:0] CR_STO  = 8'h40;
  localparam logic [7:0] CR_RD   = 8'h20;
  localparam logic [7:0] CR_WR   = 8'h10;
  localparam logic [7:0] CR_NACK = 8'h08;

  // Command values actually issued
  localparam logic [7:0] CMD_STA_WR      = CR_STA | CR_WR;            // 8'h90
  localparam logic [7:0] CMD_WR          = CR_WR;                     // 8'h10
  localparam logic [7:0] CMD_STO_WR      = CR_STO | CR_WR;            // 8'h50
  localparam logic [7:0] CMD_RD_NACK_STO = CR_RD | CR_NACK | CR_STO;  // 8'h68
  localparam logic [7:0] CMD_STO         = CR_STO;                    // 8'h40

  localparam logic [7:0] CTR_EN = 8'h80;

  // SR bit indices
  localparam int SR_TIP   = 1;
  localparam int SR_AL    = 5;
  localparam int SR_BUSY  = 6;
  localparam int SR_RXACK = 7;

  // Response error codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_ARB     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_ISSUE, ST_POLL, ST_STOPCMD, ST_STOPW, ST_RDRX, ST_RESP
  } state_t;

  typedef struct packed {
    logic       rd;
    logic [6:0] dev;
    logic [7:0] ridx;
    logic [7:0] wdata;
  } req_t;

  // One byte of the bus sequence: optional TXR load, then a CR command
  typedef struct packed {
    logic       has_txr;
    logic       chk_ack;
    logic       last;
    logic [7:0] txr;
    logic [7:0] cr;
  } step_t;

  // Step table indexed by step pointer and request direction
  function automatic step_t step_lookup(input logic [2:0] s, input req_t r);
    step_t e;
    e = '{1'b0, 1'b0, 1'b1, 8'h00, CMD_STO};
    case (s)
      3'd0: e = '{1'b1, 1'b1, 1'b0, {r.dev, 1'b0}, CMD_STA_WR};
      3'd1: e = '{1'b1, 1'b1, 1'b0, r.ridx, CMD_WR};
      3'd2: e = r.rd ? step_t'{1'b1, 1'b1, 1'b0, {r.dev, 1'b1}, CMD_STA_WR}
                     : step_t'{1'b1, 1'b1, 1'b1, r.wdata, CMD_STO_WR};
      3'd3: e = '{1'b0, 1'b0, 1'b1, 8'h00, CMD_RD_NACK_STO};
      default: e = '{1'b0, 1'b0, 1'b1, 8'h00, CMD_STO};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/i2c_wb_access.sv
// Single WISHBONE master access: start pulse in, done pulse + read data out.
// Bus signals are registered and held until ack; cyc drops on the edge after ack.
module i2c_wb_access (
  input  logic       wb_clk_i,
  input  logic       rst_n,
  input  logic       start,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cyc,
  output logic       we_o,
  output logic [2:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  // Launch on start when idle, hold until ack, then pulse done with captured data
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cyc   <= 1'b0;
      we_o  <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      done <= 1'b0;
      if (cyc) begin
        if (ack_i) begin
          cyc   <= 1'b0;
          done  <= 1'b1;
          rdata <= dat_i;
        end
      end else if (start) begin
        cyc   <= 1'b1;
        we_o  <= we;
        adr_o <= adr;
        dat_o <= wdata;
      end
    end
  end

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Turns one register-level request into the i2c core command sequence
// (init, start, address, data, stop) and reports completion status.
module i2c_wb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE   = 16'd99,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  output logic       init_done,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i
);

  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] LIM_M1 = CW'(POLL_LIMIT - 1);

  state_t        state;
  logic [2:0]    step;
  logic          txr_done;
  logic [CW-1:0] poll_cnt;
  req_t          req_q;
  logic [7:0]    rdata_q;
  logic [1:0]    err_q;

  logic          acc_start, acc_busy, acc_we, acc_done;
  logic [2:0]    acc_adr;
  logic [7:0]    acc_dat, acc_rdata;

  logic          nxt_we;
  logic [2:0]    nxt_adr;
  logic [7:0]    nxt_dat;
  step_t         ent;

  assign ent       = step_lookup(step, req_q);
  assign wbm_stb_o = wbm_cyc_o;

  i2c_wb_access u_acc (
    .wb_clk_i (wb_clk_i),
    .rst_n    (arst_i),
    .start    (acc_start),
    .we       (acc_we),
    .adr      (acc_adr),
    .wdata    (acc_dat),
    .done     (acc_done),
    .rdata    (acc_rdata),
    .cyc      (wbm_cyc_o),
    .we_o     (wbm_we_o),
    .adr_o    (wbm_adr_o),
    .dat_o    (wbm_dat_o),
    .dat_i    (wbm_dat_i),
    .ack_i    (wbm_ack_i)
  );

  // Bus access the current state wants to perform next
  always_comb begin
    nxt_we  = 1'b0;
    nxt_adr = ADR_SR;
    nxt_dat = 8'h00;
    case (state)
      ST_INIT: begin
        nxt_we = 1'b1;
        case (step)
          3'd0:    begin nxt_adr = ADR_PRERLO; nxt_dat = PRESCALE[7:0];  end
          3'd1:    begin nxt_adr = ADR_PRERHI; nxt_dat = PRESCALE[15:8]; end
          default: begin nxt_adr = ADR_CTR;    nxt_dat = CTR_EN;         end
        endcase
      end
      ST_ISSUE: begin
        nxt_we = 1'b1;
        if (ent.has_txr && !txr_done) begin
          nxt_adr = ADR_TXR;
          nxt_dat = ent.txr;
        end else begin
          nxt_adr = ADR_CR;
          nxt_dat = ent.cr;
        end
      end
      ST_STOPCMD: begin
        nxt_we  = 1'b1;
        nxt_adr = ADR_CR;
        nxt_dat = CMD_STO;
      end
      ST_RDRX: nxt_adr = ADR_RXR;
      default: nxt_adr = ADR_SR;
    endcase
  end

  // Sequencer FSM: one bus access per visit, advance on its done pulse
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state     <= ST_INIT;
      step      <= '0;
      txr_done  <= 1'b0;
      poll_cnt  <= '0;
      req_q     <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_OK;
      acc_start <= 1'b0;
      acc_busy  <= 1'b0;
      acc_we    <= 1'b0;
      acc_adr   <= '0;
      acc_dat   <= '0;
      init_done <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      acc_start <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_q     <= '{req_rd, req_dev, req_reg, req_wdata};
            step      <= '0;
            txr_done  <= 1'b0;
            err_q     <= ERR_OK;
            rdata_q   <= '0;
            req_ready <= 1'b0;
            state     <= ST_ISSUE;
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= rdata_q;
          rsp_err   <= err_q;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          if (!acc_busy) begin
            acc_start <= 1'b1;
            acc_busy  <= 1'b1;
            acc_we    <= nxt_we;
            acc_adr   <= nxt_adr;
            acc_dat   <= nxt_dat;
          end else if (acc_done) begin
            acc_busy <= 1'b0;
            case (state)
              ST_INIT: begin
                if (step == 3'd2) begin
                  step      <= '0;
                  init_done <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
                end else begin
                  step <= step + 3'd1;
                end
              end
              ST_ISSUE: begin
                if (ent.has_txr && !txr_done) begin
                  txr_done <= 1'b1;
                end else begin
                  poll_cnt <= '0;
                  state    <= ST_POLL;
                end
              end
              ST_POLL: begin
                poll_cnt <= poll_cnt + 1'b1;
                if (!acc_rdata[SR_TIP]) begin
                  if (acc_rdata[SR_AL]) begin
                    err_q <= ERR_ARB;
                    state <= ST_RESP;
                  end else if (acc_rdata[SR_RXACK] && ent.chk_ack) begin
                    err_q <= ERR_NACK;
                    state <= ST_STOPCMD;
                  end else if (ent.last) begin
                    state <= req_q.rd ? ST_RDRX : ST_RESP;
                  end else begin
                    step     <= step + 3'd1;
                    txr_done <= 1'b0;
                    state    <= ST_ISSUE;
                  end
                end else if (poll_cnt == LIM_M1) begin
                  err_q <= ERR_TIMEOUT;
                  state <= ST_STOPCMD;
                end
              end
              ST_STOPCMD: begin
                poll_cnt <= '0;
                state    <= ST_STOPW;
              end
              ST_STOPW: begin
                poll_cnt <= poll_cnt + 1'b1;
                if (!acc_rdata[SR_BUSY] || poll_cnt == LIM_M1) state <= ST_RESP;
              end
              ST_RDRX: begin
                rdata_q <= acc_rdata;
                state   <= ST_RESP;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
